// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the dual-clock FIFO, used by both the write-side and read-side flag blocks.
package fifo_pkg;

  localparam int DEFAULT_PTR_WIDTH = 8;
  localparam int MAX_PTR_BITS      = 32;

  typedef logic [MAX_PTR_BITS-1:0] ptr_word_t;

  // Callers zero-extend into ptr_word_t and cast the result back to their own width.
  // Leading zeros leave both conversions unchanged, so one function serves every pointer width.
  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin = gray;
    for (int i = MAX_PTR_BITS - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-bit flop-chain synchronizer for Gray-coded pointers crossing clock domains.
module ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // NOTE: non-blocking assignments let every stage capture its predecessor's pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/wr_full.sv
// Write-side pointer and flag controller of the dual-clock FIFO: write pointer, Gray copy,
// synchronized read pointer, full / almost_full / level and sticky overflow.
module wr_full
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH       = DEFAULT_PTR_WIDTH,
  parameter int ALMOST_FULL_GAP = 3,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst,
  input  logic                 wr_en,
  input  logic                 overflow_clr,
  input  logic [PTR_WIDTH:0]   r_ptr_gray,
  output logic [PTR_WIDTH-1:0] wr_addr,
  output logic                 mem_we,
  output logic [PTR_WIDTH:0]   wr_ptr_gray,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   wr_level,
  output logic                 overflow
);

  localparam int PW1   = PTR_WIDTH + 1;
  localparam int DEPTH = 2 ** PTR_WIDTH;

  typedef logic [PTR_WIDTH:0] ptr_t;

  localparam ptr_t AF_LEVEL = ptr_t'(DEPTH - ALMOST_FULL_GAP);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t wr_gray_q, wr_gray_d;
  ptr_t r2w_gray, r2w_bin;
  logic overflow_q, overflow_d;

  ptr_sync #(
    .WIDTH  (PW1),
    .STAGES (SYNC_STAGES)
  ) u_r2w_sync (
    .clk (wr_clk),
    .rst (wr_rst),
    .d_i (r_ptr_gray),
    .q_o (r2w_gray)
  );

  assign r2w_bin = ptr_t'(gray2bin(ptr_word_t'(r2w_gray)));

  // Full when the write pointer is exactly one lap ahead: in Gray code that means the top two bits differ.
  assign full        = (wr_gray_q == {~r2w_gray[PTR_WIDTH -: 2], r2w_gray[PTR_WIDTH-2:0]});
  assign wr_level    = wr_ptr_q - r2w_bin;
  assign almost_full = (wr_level >= AF_LEVEL);
  assign mem_we      = wr_en && !full;
  assign wr_addr     = wr_ptr_q[PTR_WIDTH-1:0];
  assign wr_ptr_gray = wr_gray_q;
  assign overflow    = overflow_q;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    if (mem_we) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
    wr_gray_d = ptr_t'(bin2gray(ptr_word_t'(wr_ptr_d)));
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_ptr_q   <= '0;
      wr_gray_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      wr_gray_q  <= wr_gray_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: doc/wr_full.md
# wr_full

Write-side pointer and flag controller for the dual-clock FIFO, the write-domain counterpart of the read-side empty logic. It owns the write pointer and its registered Gray-coded copy for crossing to the read domain. It synchronizes the read pointer into the write clock domain and produces `full`, `almost_full`, a fill level and a sticky overflow flag. It drives the write port of the shared FIFO memory.

## Interface
- `PTR_WIDTH`, 8: memory address width; depth `DEPTH = 2**PTR_WIDTH`; must be >= 2.
- `ALMOST_FULL_GAP`, 3: `almost_full` threshold in free entries; must be < `DEPTH`.
- `SYNC_STAGES`, 2: flops in the read-pointer synchronizer; must be >= 2.

- `wr_clk`  in  1  write-domain clock.
- `wr_rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write request.
- `overflow_clr`  in  1  clears `overflow`.
- `r_ptr_gray`  in  PTR_WIDTH+1  Gray read pointer, straight from the read domain (unsynchronized).
- `wr_addr`  out  PTR_WIDTH  memory write address, `wr_ptr[PTR_WIDTH-1:0]`.
- `mem_we`  out  1  memory write enable, `wr_en && !full`.
- `wr_ptr_gray`  out  PTR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- `full`  out  1  FIFO full.
- `almost_full`  out  1  free entries <= `ALMOST_FULL_GAP`.
- `wr_level`  out  PTR_WIDTH+1  occupancy as seen from the write domain, 0..DEPTH.
- `overflow`  out  1  sticky flag: a write was attempted while full.

## Operation
- Registers:
  - binary `wr_ptr` (PTR_WIDTH+1 bits).
  - `wr_ptr_gray` register.
  - synchronizer chain `r2w_gray`.
  - `overflow`.
- Accepted write (`wr_en && !full` at a `wr_clk` edge):
  - `wr_ptr <= wr_ptr + 1`, modulo 2^(PTR_WIDTH+1).
  - `wr_ptr_gray <= bin2gray(wr_ptr + 1)` in the same edge.
  - The Gray output comes straight from a flop and never glitches.
- Rejected write (`wr_en && full`): pointers hold, `mem_we` = 0, `overflow` sets on that edge.
- `overflow`:
  - Cleared on the edge where `overflow_clr` = 1 and no rejected write occurs.
  - Set has priority when set and clear coincide.
- `full` = (`wr_ptr_gray` == {~r2w[PTR_WIDTH:PTR_WIDTH-1], r2w[PTR_WIDTH-2:0]}), where r2w is the last synchronizer stage. It is combinational from registers.
- `r2w_bin` = gray2bin(r2w), computed combinationally.
- `wr_level` = (`wr_ptr` − `r2w_bin`) mod 2^(PTR_WIDTH+1). It is DEPTH exactly when `full`.
- `almost_full` = (`wr_level` >= DEPTH − ALMOST_FULL_GAP). It is therefore 1 whenever `full`.
- Wrap-around: the pointer rolls from all-ones to 0, and the Gray value changes one bit only. Level and flags stay correct across the wrap with no special case.
- Flags are pessimistic. The read pointer lags, so `full`/`almost_full` may stay asserted after the reader has freed space, but never deassert early.

## Timing
- Reset (async assert; deassert is synchronized externally to `wr_clk`). Values while `wr_rst` = 1 and after release:
  - 0: `wr_ptr`, `wr_ptr_gray`, all `r2w` stages, `overflow`, `wr_level`, `full`, `almost_full`.
  - `wr_addr` = 0.
  - `mem_we` follows `wr_en` (0 if idle).
- Reset mid-operation:
  - Everything returns to the values above immediately, regardless of clock.
  - The read side is reset in the same system reset.
- Write-to-flag latency:
  - `wr_addr`, `wr_ptr_gray`, `wr_level`, `full` and `almost_full` reflect an accepted write right after the same edge.
  - A write accepted when level = DEPTH−1 makes `full` = 1 immediately, so a back-to-back `wr_en` on the next cycle is rejected.
- Read-to-flag latency: a change on `r_ptr_gray` reaches `full`/`wr_level` after exactly `SYNC_STAGES` `wr_clk` edges.
- Simultaneous write and read-pointer update: the level uses the new `wr_ptr` and the current synchronized read pointer. No lost updates.

## Structure
- Shared package `fifo_pkg`:
  - functions `bin2gray`/`gray2bin`, parameterized on width.
  - a constant for the default `PTR_WIDTH`.
- The read-side block uses the same package.
- One sub-module, `ptr_sync`: `SYNC_STAGES`-deep multi-bit flop chain, async active-high reset to 0, clocked by `wr_clk`. It is reused later for the write-to-read crossing.

## Test plan
Bench uses PTR_WIDTH=3 (DEPTH 8), ALMOST_FULL_GAP=3, SYNC_STAGES=2.
- Fill from reset, `r_ptr_gray`=0, `wr_en`=1 for 8 cycles:
  - `wr_addr` goes 0..7.
  - `wr_ptr_gray` goes 0,1,3,2,6,7,5,4 and then 0b1100.
  - `almost_full` rises after write 5 (level 5).
  - `full` and level 8 appear after write 8.
- Write while full, `wr_en` held 1:
  - `mem_we`=0 and `wr_ptr` is unchanged.
  - `overflow`=1 after the edge and stays 1 until `overflow_clr`.
  - Clear and attempt in the same cycle keeps `overflow`=1.
- Release: while full, set `r_ptr_gray`=gray(2)=0b0011.
  - `full` drops exactly 2 edges later, with `wr_level`=6 and `almost_full`=1.
  - Set `r_ptr_gray`=gray(5): `almost_full` drops 2 edges later (level 3).
- Wrap: 20 writes with `r_ptr_gray` trailing by 2.
  - `wr_ptr` goes 15→0, with `wr_ptr_gray` 0b1000→0b0000.
  - `wr_level` stays 2 throughout; no flags assert.
- Reset mid-operation: assert `wr_rst` between clock edges at `wr_ptr`=5.
  - All outputs go to reset values before the next edge.
  - Writes resume from `wr_addr`=0 after release.
